uart_fifo_mmio: RTL and testbench

//  Memory-mapped front end for the uart core: CPU data bus on one side, the uart byte handshake on the other.

---
 rtl/uart_fifo_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_fifo_mmio.sv | 162 ++++++++++++++++
 tb/tb_uart_fifo_mmio.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - register map, status/ctrl bit indices and TX FSM states for uart_fifo_mmio
package uart_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_TX_IDLE  = 6;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Last WAIT_HI cycle index before giving up on seeing tx_busy rise.
  localparam logic [1:0] WAIT_HI_LAST = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with head-of-queue read data and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - MMIO DATA/STATUS/CTRL front end with TX/RX FIFOs for the uart core
// Optional interrupt output enabled by defining UART_FIFO_IRQ_EN.
module uart_fifo_mmio
  import uart_fifo_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        irq
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [1:0]     sel;
  logic           rd, wr;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_pop, rx_full, rx_empty;
  logic [7:0]     tx_head, rx_head;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           tx_idle;
  logic [31:0]    status;
  logic [31:0]    rdata_q, rdata_d;
  logic           tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [1:0]     ctrl_q, ctrl_d;
  tx_state_t      state_q;
  logic [1:0]     wait_cnt_q;
  logic [7:0]     tx_data_q;
  logic           tx_req_q;
  logic           unused_bits;

  assign sel     = addr[3:2];
  assign rd      = req && !we;
  assign wr      = req && we;
  assign tx_push = wr && (sel == REG_DATA);
  assign rx_pop  = rd && (sel == REG_DATA);
  assign tx_pop  = (state_q == TX_LOAD);
  assign tx_idle = tx_empty && (state_q == TX_IDLE);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .wdata(wdata[7:0]), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_ready), .wdata(rx_data), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_IDLE]  = tx_idle;
    status[15:8]        = 8'(rx_count);
    status[23:16]       = 8'(tx_count);
  end

  always_comb begin
    rdata_d  = '0;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ctrl_d   = ctrl_q;
    if (wr && sel == REG_STATUS) begin
      if (wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
      if (wdata[ST_RX_OVF]) rx_ovf_d = 1'b0;
    end
    if (wr && sel == REG_CTRL) ctrl_d = wdata[1:0];
    // New overflow events win over a W1C in the same cycle so none is lost.
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_ready && rx_full && !rx_pop) rx_ovf_d = 1'b1;
    if (rd) begin
      case (sel)
        REG_DATA:   rdata_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
        REG_STATUS: rdata_d = status;
        REG_CTRL:   rdata_d = {30'b0, ctrl_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      rdata_q  <= rdata_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= TX_IDLE;
      wait_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_req_q   <= 1'b0;
    end else begin
      tx_req_q <= 1'b0;
      case (state_q)
        TX_IDLE: if (!tx_empty && !tx_busy) state_q <= TX_LOAD;
        TX_LOAD: begin
          tx_data_q  <= tx_head;
          tx_req_q   <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= TX_WAIT_HI;
        end
        // An instantly-completing uart never raises tx_busy, hence the timeout.
        TX_WAIT_HI: begin
          if (tx_busy || wait_cnt_q == WAIT_HI_LAST) state_q <= TX_WAIT_LO;
          else wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        TX_WAIT_LO: if (!tx_busy) state_q <= TX_IDLE;
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign tx_data = tx_data_q;
  assign tx_req  = tx_req_q;

`ifdef UART_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (ctrl_q[CTRL_RX_IE] && !rx_empty) || (ctrl_q[CTRL_TX_IE] && tx_empty) ||
            tx_ovf_q || rx_ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb/tb_uart_fifo_mmio.sv - directed self-checking bench for uart_fifo_mmio
module tb_uart_fifo_mmio;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        irq;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  tx_log[$];
  int          req_bad = 0;
  logic        prev_req = 1'b0;
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  logic        model_en = 1'b1;
  logic [31:0] d;

  uart_fifo_mmio #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Uart model: goes busy for 5 cycles after each tx_req; logs sent bytes.
  always @(negedge clk) begin
    if (tx_req) begin
      tx_log.push_back(tx_data);
      if (tx_busy || prev_req) req_bad++;
    end
    prev_req = tx_req;
    if (model_en && tx_req) busy_cnt = 5;
    else if (busy_cnt != 0) busy_cnt--;
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = v;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    v = rdata;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int cyc = 0;
    while (tx_log.size() < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_count_reached", tx_log.size(), n);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_tx_req", {31'b0, tx_req}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rstn = 1'b1;
    bus_read(4'h4, d); check("rst_status", d, 32'h0000004A);
    bus_read(4'h8, d); check("rst_ctrl", d, 32'h0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'hC, d); check("reg_c_reads_0", d, 32'h0);

    bus_write(4'h0, 32'h48);
    bus_write(4'h0, 32'h69);
    wait_tx(2);
    check("tx_byte0", {24'b0, tx_log[0]}, 32'h48);
    check("tx_byte1", {24'b0, tx_log[1]}, 32'h69);
    check("tx_data_hold", {24'b0, tx_data}, 32'h69);
    check("tx_req_spacing", req_bad, 0);
    bus_read(4'h4, d); check("tx_idle_end", d, 32'h0000004A);

    rx_inject(8'h32); rx_inject(8'h2B); rx_inject(8'h32);
    bus_read(4'h4, d); check("rx3_status", d, 32'h00000342);
    bus_read(4'h0, d); check("rx3_rd0", d, 32'h132);
    bus_read(4'h0, d); check("rx3_rd1", d, 32'h12B);
    bus_read(4'h0, d); check("rx3_rd2", d, 32'h132);
    bus_read(4'h0, d); check("rx3_rd_empty", d, 32'h000);

    for (int i = 0; i < 17; i++) rx_inject(8'hA0 + 8'(i));
    bus_read(4'h4, d); check("rx_ovf_status", d, 32'h00001066);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h0, d); check("rx_ovf_byte", d, 32'h100 | (32'hA0 + i));
    end
    bus_read(4'h4, d); check("rx_drained_status", d, 32'h0000006A);
    bus_write(4'h4, 32'h20);
    bus_read(4'h4, d); check("rx_ovf_w1c", d, 32'h0000004A);

    for (int i = 0; i < 16; i++) rx_inject(8'h10 + 8'(i));
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 4'h0; rx_ready = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    req = 1'b0; rx_ready = 1'b0;
    check("full_rdwr_byte", rdata, 32'h110);
    bus_read(4'h4, d); check("full_rdwr_status", d, 32'h00001046);
    for (int i = 1; i < 16; i++) begin
      bus_read(4'h0, d); check("full_rdwr_drain", d, 32'h100 | (32'h10 + i));
    end
    bus_read(4'h0, d); check("full_rdwr_last", d, 32'h155);

    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(4'h0, 32'hC0 + i);
    bus_read(4'h4, d); check("tx_full_status", d, 32'h00100019);
    check("tx_none_while_busy", tx_log.size(), 2);
    hold_busy = 1'b0;
    wait_tx(18);
    for (int i = 0; i < 16; i++) check("tx_full_order", {24'b0, tx_log[2+i]}, 32'hC0 + i);
    check("tx_req_spacing2", req_bad, 0);
    bus_read(4'h4, d); check("tx_ovf_sticky", d, 32'h0000005A);
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, d); check("tx_ovf_w1c", d, 32'h0000004A);

    model_en = 1'b0;
    bus_write(4'h0, 32'h77);
    wait_tx(19);
    check("tx_timeout_byte", {24'b0, tx_log[18]}, 32'h77);
    bus_read(4'h4, d); check("tx_timeout_idle", d, 32'h0000004A);
    model_en = 1'b1;

    bus_write(4'h8, 32'hFFFF_FFFD);
    bus_read(4'h8, d); check("ctrl_rw", d, 32'h1);
    rx_inject(8'h5A);
    @(negedge clk);
`ifdef UART_FIFO_IRQ_EN
    check("irq_rx_set", {31'b0, irq}, 32'h1);
`else
    check("irq_tied_rx", {31'b0, irq}, 32'h0);
`endif
    bus_read(4'h0, d); check("irq_rx_byte", d, 32'h15A);
    @(negedge clk);
    check("irq_rx_clr", {31'b0, irq}, 32'h0);

    rx_inject(8'h01);
    bus_write(4'h0, 32'hA1);
    bus_write(4'h0, 32'hA2);
    begin
      int cyc = 0;
      while (!tx_req && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("mid_send_seen", {31'b0, tx_req}, 32'h1);
    end
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_req", {31'b0, tx_req}, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    bus_read(4'h4, d); check("mid_rst_status", d, 32'h0000004A);
    bus_read(4'h8, d); check("mid_rst_ctrl", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
